// File: rtl/bmac_pkg.sv
// Shared types and helpers for the binary-MAC accumulator path.
// Saturating add is written once here so later bias/batch-norm stages clamp identically.
package bmac_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Internal width wide enough for any accumulator this family will use
    localparam int SAT_W = 64;

    // Narrowest accumulator that can hold one worst-case contribution plus sign
    function automatic int min_acc_width(input int in_width);
        return $clog2(in_width) + 2;
    endfunction

    // Returns {clamp, value}; value is a + b clamped to a signed 'width'-bit range
    function automatic logic [SAT_W:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      width
    );
        logic signed [SAT_W:0] s;
        logic signed [SAT_W:0] one;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        logic        [SAT_W:0] r;
        one    = '0;
        one[0] = 1'b1;
        s      = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi     = (one <<< (width - 1)) - one;
        lo     = -(one <<< (width - 1));
        if (s > hi) begin
            r = {1'b1, hi[SAT_W-1:0]};
        end else if (s < lo) begin
            r = {1'b1, lo[SAT_W-1:0]};
        end else begin
            r = {1'b0, s[SAT_W-1:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/bmac_sat_add.sv
// Combinational signed clamp-and-add: o_sum = sat(i_acc + i_c), o_clamp flags a clamp.
// Zero latency; no flow control.
module bmac_sat_add
    import bmac_pkg::*;
#(
    parameter int ACC_WIDTH = 24
) (
    input  logic [ACC_WIDTH-1:0] i_acc,
    input  logic [ACC_WIDTH:0]   i_c,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic                 o_clamp
);

    logic [SAT_W-1:0] w_acc_ext;
    logic [SAT_W-1:0] w_c_ext;
    logic [SAT_W:0]   w_res;
    logic             w_unused_hi;

    assign w_acc_ext   = {{(SAT_W - ACC_WIDTH){i_acc[ACC_WIDTH-1]}}, i_acc};
    assign w_c_ext     = {{(SAT_W - ACC_WIDTH - 1){i_c[ACC_WIDTH]}}, i_c};
    assign w_res       = sat_add(w_acc_ext, w_c_ext, ACC_WIDTH);
    assign o_sum       = w_res[ACC_WIDTH-1:0];
    assign o_clamp     = w_res[SAT_W];
    // Clamped result always fits ACC_WIDTH, upper bits are pure sign copies
    assign w_unused_hi = ^w_res[SAT_W-1:ACC_WIDTH];

endmodule

// File: rtl/bmac_acc.sv
// Accumulates +/-1 dot-product contributions per vector and registers sum, activation, count, saturation.
// Result one cycle after the last beat; pop_ready follows out_ready while a result is held.
module bmac_acc
    import bmac_pkg::*;
#(
    parameter int IN_WIDTH     = 32,
    parameter int OUTPUT_WIDTH = 16,
    parameter int ACC_WIDTH    = 24,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OUTPUT_WIDTH-1:0] pop_in,
    input  logic                    pop_valid,
    input  logic                    pop_last,
    output logic                    pop_ready,
    input  logic [ACC_WIDTH-1:0]    cfg_threshold,
    output logic [ACC_WIDTH-1:0]    acc_out,
    output logic                    act_out,
    output logic [CNT_WIDTH-1:0]    words_out,
    output logic                    sat_out,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int CW = ACC_WIDTH + 1;

    generate
        if (ACC_WIDTH < min_acc_width(IN_WIDTH)) begin : g_acc_width_chk
            $error("bmac_acc: ACC_WIDTH too small for IN_WIDTH");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_pop_rdy;
    logic                 w_accept;
    logic                 w_load;

    logic [CW-1:0]        w_p;
    logic [CW-1:0]        w_c;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_clamp;
    logic                 w_act;
    logic [CNT_WIDTH-1:0] w_cnt_inc;

    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_sat;

    logic [ACC_WIDTH-1:0] r_res_acc;
    logic                 r_res_act;
    logic [CNT_WIDTH-1:0] r_res_words;
    logic                 r_res_sat;

    // Popcounts above IN_WIDTH are impossible from a healthy MAC; clamp rather than trust them
    assign w_p       = (32'(pop_in) > 32'(IN_WIDTH)) ? CW'(IN_WIDTH) : CW'(pop_in);
    assign w_c       = (w_p << 1) - CW'(IN_WIDTH);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_act     = $signed(w_sum) >= $signed(cfg_threshold);

    bmac_sat_add #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_add (
        .i_acc   (r_acc),
        .i_c     (w_c),
        .o_sum   (w_sum),
        .o_clamp (w_clamp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop_rdy   = 1'b0;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ACCUM: begin
                w_pop_rdy = 1'b1;
                w_accept  = pop_valid;
                w_load    = pop_valid & pop_last;
                if (w_load) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_pop_rdy = out_ready;
                w_accept  = pop_valid & out_ready;
                w_load    = pop_valid & out_ready & pop_last;
                if (out_ready && !w_load) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_res_acc   <= '0;
            r_res_act   <= 1'b0;
            r_res_words <= '0;
            r_res_sat   <= 1'b0;
        end else if (w_accept) begin
            if (w_load) begin
                r_acc       <= '0;
                r_cnt       <= '0;
                r_sat       <= 1'b0;
                r_res_acc   <= w_sum;
                r_res_act   <= w_act;
                r_res_words <= w_cnt_inc;
                r_res_sat   <= r_sat | w_clamp;
            end else begin
                r_acc <= w_sum;
                r_cnt <= w_cnt_inc;
                r_sat <= r_sat | w_clamp;
            end
        end
    end

    assign pop_ready = w_pop_rdy;
    assign out_valid = (r_state == HOLD);
    assign acc_out   = r_res_acc;
    assign act_out   = r_res_act;
    assign words_out = r_res_words;
    assign sat_out   = r_res_sat;

endmodule

// File: tb/tb_bmac_acc.sv
// Directed bench for bmac_acc: a default 24-bit instance and an 8-bit instance share stimulus.
module tb_bmac_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pop_in = '0;
    logic        pop_valid = 1'b0;
    logic        pop_last = 1'b0;
    logic        pop_ready;
    logic [23:0] thr = '0;
    logic [23:0] acc_out;
    logic        act_out;
    logic [7:0]  words_out;
    logic        sat_out;
    logic        out_valid;
    logic        out_ready = 1'b1;

    logic        pop_ready8;
    logic [7:0]  acc8;
    logic        act8;
    logic [7:0]  words8;
    logic        sat8;
    logic        out_valid8;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bmac_acc u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pop_in        (pop_in),
        .pop_valid     (pop_valid),
        .pop_last      (pop_last),
        .pop_ready     (pop_ready),
        .cfg_threshold (thr),
        .acc_out       (acc_out),
        .act_out       (act_out),
        .words_out     (words_out),
        .sat_out       (sat_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    bmac_acc #(
        .ACC_WIDTH (8)
    ) u_dut8 (
        .clk           (clk),
        .rst_n         (rst_n),
        .pop_in        (pop_in),
        .pop_valid     (pop_valid),
        .pop_last      (pop_last),
        .pop_ready     (pop_ready8),
        .cfg_threshold (thr[7:0]),
        .acc_out       (acc8),
        .act_out       (act8),
        .words_out     (words8),
        .sat_out       (sat8),
        .out_valid     (out_valid8),
        .out_ready     (out_ready)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, return #1 after the accepting edge
    task automatic send(input int pop, input bit last);
        int n;
        n         = 0;
        pop_in    = 16'(pop);
        pop_last  = last;
        pop_valid = 1'b1;
        #1;
        while (!pop_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        pop_valid = 1'b0;
        pop_last  = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_acc", $signed(acc_out), 0);
        chk("rst_act", act_out, 0);
        chk("rst_words", words_out, 0);
        chk("rst_sat", sat_out, 0);
        chk("rst_pop_ready", pop_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single beat, 2*20-32 = 8
        thr = 24'sd0;
        send(20, 1);
        chk("t1_valid", out_valid, 1);
        chk("t1_acc", $signed(acc_out), 8);
        chk("t1_act", act_out, 1);
        chk("t1_words", words_out, 1);
        chk("t1_sat", sat_out, 0);

        // 2: 32 - 32 - 12 = -12 against -10
        thr = -24'sd10;
        send(32, 0);
        send(0, 0);
        send(10, 1);
        chk("t2_valid", out_valid, 1);
        chk("t2_acc", $signed(acc_out), -12);
        chk("t2_act", act_out, 0);
        chk("t2_words", words_out, 3);
        chk("t2_acc8", $signed(acc8), -12);

        // 3: stall with a pending last beat, then release
        out_ready = 1'b0;
        pop_in    = 16'd16;
        pop_last  = 1'b1;
        pop_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("t3_pop_ready", pop_ready, 0);
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_acc", $signed(acc_out), -12);
            chk("t3_hold_words", words_out, 3);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        pop_valid = 1'b0;
        pop_last  = 1'b0;
        chk("t3_valid", out_valid, 1);
        chk("t3_acc", $signed(acc_out), 0);
        chk("t3_words", words_out, 1);
        chk("t3_act", act_out, 1);

        // 4: five full beats; 8-bit copy clamps at 127, 24-bit reaches 160
        thr = 24'sd0;
        for (int i = 0; i < 4; i++) send(32, 0);
        send(32, 1);
        chk("t4_acc8", $signed(acc8), 127);
        chk("t4_sat8", sat8, 1);
        chk("t4_words8", words8, 5);
        chk("t4_act8", act8, 1);
        chk("t4_acc24", $signed(acc_out), 160);
        chk("t4_sat24", sat_out, 0);
        send(16, 1);
        chk("t4b_acc8", $signed(acc8), 0);
        chk("t4b_sat8", sat8, 0);
        chk("t4b_words8", words8, 1);

        // 5: async reset drops a held result
        send(10, 0);
        out_ready = 1'b0;
        send(10, 1);
        chk("t5_pre_valid", out_valid, 1);
        chk("t5_pre_acc", $signed(acc_out), -24);
        chk("t5_pre_words", words_out, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", out_valid, 0);
        chk("t5_async_acc", $signed(acc_out), 0);
        chk("t5_async_words", words_out, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(0, 1);
        chk("t5_acc", $signed(acc_out), -32);
        chk("t5_words", words_out, 1);
        chk("t5_act", act_out, 0);
        chk("t5_sat", sat_out, 0);

        // 6: popcount above IN_WIDTH clamps; threshold is inclusive
        thr = 24'sd32;
        send(40, 1);
        chk("t6_acc", $signed(acc_out), 32);
        chk("t6_act", act_out, 1);
        chk("t6_words", words_out, 1);
        send(31, 1);
        chk("t6b_acc", $signed(acc_out), 30);
        chk("t6b_act", act_out, 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/bmac_acc.md
Name: bmac_acc

Overview:
- Sequential accumulator directly downstream of the combinational binary MAC (XNOR + popcount).
- Consumes one popcount per IN_WIDTH-bit word, converts it to a signed ±1 dot-product contribution (2*pop − IN_WIDTH), and accumulates over a variable-length vector delimited by a last flag.
- Emits the signed sum, a binarized activation (sum ≥ threshold), a word count and a saturation flag through a valid/ready output register.

Parameters:
- IN_WIDTH, 32, bits per binary word fed to the upstream MAC; maximum legal popcount.
- OUTPUT_WIDTH, 16, width of the incoming popcount.
- ACC_WIDTH, 24, signed accumulator and result width; must be ≥ clog2(IN_WIDTH)+2.
- CNT_WIDTH, 8, word-counter width; counter saturates at all-ones.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- pop_in  input  OUTPUT_WIDTH  unsigned popcount from the upstream MAC.
- pop_valid  input  1  pop_in/pop_last valid.
- pop_last  input  1  final word of the current vector.
- pop_ready  output  1  beat accepted when pop_valid & pop_ready.
- cfg_threshold  input  ACC_WIDTH  signed activation threshold, sampled on the last beat.
- acc_out  output  ACC_WIDTH  signed vector sum.
- act_out  output  1  1 when acc_out ≥ threshold (signed compare).
- words_out  output  CNT_WIDTH  number of words in the vector (saturating).
- sat_out  output  1  accumulator clamped at least once in this vector.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  downstream takes the result when out_valid & out_ready.

Behaviour:
- Reset (async assert, sync release): acc=0, word_cnt=0, sat flag=0, state=ACCUM. Outputs acc_out=0, act_out=0, words_out=0, sat_out=0, out_valid=0. pop_ready is driven combinationally from state and is 1 after reset.
- Contribution per accepted beat: p = min(pop_in, IN_WIDTH), so values above IN_WIDTH clamp. c = 2*p − IN_WIDTH, sign-extended to ACC_WIDTH+1.
- Saturating add: next = acc + c, clamped to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]. Any clamp sets the per-vector sat flag.
- word_cnt increments per accepted beat and saturates at 2^CNT_WIDTH−1.
- States:
  - ACCUM: pop_ready=1.
    - Beat without last: update acc and word_cnt.
    - Beat with last: load the result register with the final sum (including this beat), act = sum ≥ cfg_threshold, words = word_cnt+1 (saturated), sat = flag | this-beat clamp. Set out_valid=1. Clear acc, word_cnt and the sat flag in the same edge. Go to HOLD.
  - HOLD: pop_ready = out_ready.
    - out_ready=1: result consumed. A simultaneous input beat is processed exactly as in ACCUM, including back-to-back last, which reloads the result and stays in HOLD. Otherwise go to ACCUM and out_valid=0.
    - out_ready=0: all result outputs hold stable; no input accepted.
- Latency: result is visible on the cycle after the last beat is accepted; full throughput of one beat per cycle while out_ready=1.
- Single-word vector: first beat with last produces c directly, words=1.
- Reset mid-vector or mid-HOLD: the partial sum and any pending result are discarded; out_valid drops immediately (asynchronously).
- Outputs are fully registered. pop_ready is a combinational function of state and out_ready only, with no path from pop_valid.

Decomposition:
- Package bmac_pkg: state enum {ACCUM, HOLD}; a constant function for the clog2-based minimum ACC_WIDTH check; a saturating-add helper function.
- One natural sub-module, bmac_sat_add: combinational clamp-and-add (inputs acc and c, outputs sum and clamp flag). It is reusable by later bias/batch-norm stages.
- Top-level holds the FSM, counter and result register.

Test Plan:
1. IN_WIDTH=32, single beat pop=20, last=1, threshold=0 → next cycle out_valid=1, acc_out=8, act_out=1, words_out=1, sat_out=0.
2. Beats pop=32, 0, 10 (last on third), threshold=−10 → acc_out=−12, act_out=0, words_out=3.
3. Hold out_ready=0 after the result → pop_ready=0 and outputs stable for 5 cycles. Raise out_ready with a pending last beat pop=16 → same edge consumes the old result and loads acc_out=0, words_out=1.
4. ACC_WIDTH=8 override, five beats pop=32 with last → acc_out=127, sat_out=1, words_out=5. The next vector pop=16, last → acc_out=0, sat_out=0.
5. Two beats accepted, then rst_n low mid-cycle → out_valid=0 asynchronously. After release, beat pop=0, last → acc_out=−32, words_out=1, with no residue from before reset.
6. pop_in=40 (above IN_WIDTH), last → contribution clamped, acc_out=32, act_out=1 with threshold=32.
